// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DMC read-gate calibration logic: sequencer states,
// tap count and a run-length helper used by the window finder.
package bsg_dmc_pkg;

    localparam int dmc_cal_taps_gp = 8;

    typedef enum logic [2:0] {
        CAL_IDLE,
        CAL_SETTLE,
        CAL_ISSUE,
        CAL_WAIT,
        CAL_EVAL,
        CAL_PICK,
        CAL_DONE
    } cal_state_e;

    // Number of contiguous set bits in mask beginning at index start (no wrap).
    function automatic logic [3:0] run_length(input logic [dmc_cal_taps_gp-1:0] mask,
                                              input int start);
        logic [3:0] len;
        logic       stop;
        len  = '0;
        stop = 1'b0;
        for (int j = 0; j < dmc_cal_taps_gp; j++) begin
            if (j >= start && !stop) begin
                if (mask[j]) len = len + 4'd1;
                else         stop = 1'b1;
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/bsg_dmc_cal_window_finder.sv
// Picks the centre tap of the longest run of passing taps; the lowest-starting
// run wins a tie, and an even-length run rounds its centre down.
module bsg_dmc_cal_window_finder
    import bsg_dmc_pkg::*;
(
    input  logic [dmc_cal_taps_gp-1:0] mask_i,
    output logic                       found_o,
    output logic [2:0]                 tap_o
);

    logic [3:0] run_len [dmc_cal_taps_gp];

    for (genvar gi = 0; gi < dmc_cal_taps_gp; gi++) begin : g_run
        assign run_len[gi] = run_length(mask_i, gi);
    end

    logic [3:0] best_len;
    logic [2:0] best_start;

    always_comb begin
        best_len   = '0;
        best_start = '0;
        // Strict '>' keeps the earliest start when lengths tie.
        for (int s = 0; s < dmc_cal_taps_gp; s++) begin
            if (run_len[s] > best_len) begin
                best_len   = run_len[s];
                best_start = 3'(s);
            end
        end
        found_o = (best_len != 4'd0);
        tap_o   = best_start + 3'((best_len - 4'd1) >> 1);
    end

endmodule

// File: rtl/bsg_dmc_dqs_gate_cal.sv
// DQS read-gate calibration: sweeps the 8 gate taps, issues training reads on
// each, and drives the centre of the widest passing window to the PHY.
module bsg_dmc_dqs_gate_cal
    import bsg_dmc_pkg::*;
#(
    parameter int dq_data_width_p = 8,
    parameter int reads_per_tap_p = 4,
    parameter int settle_p        = 8,
    parameter int timeout_p       = 64,
    parameter int default_tap_p   = 0
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    output logic                           rd_req_o,
    input  logic                           rd_ready_i,
    input  logic                           rddata_valid_i,
    input  logic [2*dq_data_width_p-1:0]   rddata_i,
    input  logic [2*dq_data_width_p-1:0]   expected_i,
    output logic [2:0]                     dqs_sel_cal_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           fail_o,
    output logic [dmc_cal_taps_gp-1:0]     pass_mask_o
);

    localparam int rd_cnt_w_lp     = $clog2(reads_per_tap_p + 1);
    localparam int settle_cnt_w_lp = $clog2(settle_p + 1);
    localparam int to_cnt_w_lp     = $clog2(timeout_p + 1);

    localparam logic [rd_cnt_w_lp-1:0]     reads_lp       = rd_cnt_w_lp'(reads_per_tap_p);
    localparam logic [settle_cnt_w_lp-1:0] settle_last_lp = settle_cnt_w_lp'(settle_p - 1);
    localparam logic [to_cnt_w_lp-1:0]     to_limit_lp    = to_cnt_w_lp'(timeout_p);
    localparam logic [2:0]                 default_tap_lp = 3'(default_tap_p);
    localparam logic [2:0]                 last_tap_lp    = 3'(dmc_cal_taps_gp - 1);

    cal_state_e                   state_reg, state_next;
    logic [2:0]                   tap_reg;
    logic [2:0]                   dqs_sel_reg;
    logic [rd_cnt_w_lp-1:0]       rd_cnt_reg;
    logic [settle_cnt_w_lp-1:0]   settle_cnt_reg;
    logic [to_cnt_w_lp-1:0]       to_cnt_reg;
    logic                         tap_ok_reg;
    logic                         done_reg;
    logic                         fail_reg;
    logic [dmc_cal_taps_gp-1:0]   pass_mask_reg;

    logic       settle_done, timed_out, reads_left, last_tap;
    logic       win_found;
    logic [2:0] win_tap;

    assign settle_done = (settle_cnt_reg == settle_last_lp);
    assign timed_out   = (to_cnt_reg == to_limit_lp);
    assign reads_left  = (rd_cnt_reg < reads_lp);
    assign last_tap    = (tap_reg == last_tap_lp);

    bsg_dmc_cal_window_finder window_finder (
        .mask_i  (pass_mask_reg),
        .found_o (win_found),
        .tap_o   (win_tap)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            CAL_IDLE, CAL_DONE: if (start_i)     state_next = CAL_SETTLE;
            CAL_SETTLE:         if (settle_done) state_next = CAL_ISSUE;
            CAL_ISSUE:          if (rd_ready_i)  state_next = CAL_WAIT;
            CAL_WAIT:           if (rddata_valid_i || timed_out) state_next = CAL_EVAL;
            CAL_EVAL: begin
                if (reads_left)    state_next = CAL_ISSUE;
                else if (last_tap) state_next = CAL_PICK;
                else               state_next = CAL_SETTLE;
            end
            CAL_PICK:           state_next = CAL_DONE;
            default:            state_next = CAL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg      <= CAL_IDLE;
            tap_reg        <= '0;
            dqs_sel_reg    <= default_tap_lp;
            rd_cnt_reg     <= '0;
            settle_cnt_reg <= '0;
            to_cnt_reg     <= '0;
            tap_ok_reg     <= 1'b0;
            done_reg       <= 1'b0;
            fail_reg       <= 1'b0;
            pass_mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            unique case (state_reg)
                CAL_IDLE, CAL_DONE: begin
                    if (start_i) begin
                        tap_reg        <= '0;
                        dqs_sel_reg    <= '0;
                        rd_cnt_reg     <= '0;
                        settle_cnt_reg <= '0;
                        tap_ok_reg     <= 1'b1;
                        done_reg       <= 1'b0;
                        fail_reg       <= 1'b0;
                        pass_mask_reg  <= '0;
                    end
                end
                CAL_SETTLE: begin
                    if (!settle_done) settle_cnt_reg <= settle_cnt_reg + 1'b1;
                end
                CAL_ISSUE: begin
                    if (rd_ready_i) begin
                        to_cnt_reg <= to_cnt_w_lp'(1);
                        if (rd_cnt_reg != reads_lp) rd_cnt_reg <= rd_cnt_reg + 1'b1;
                    end
                end
                CAL_WAIT: begin
                    // A beat landing on the expiry cycle is judged on its data.
                    if (rddata_valid_i ? (rddata_i != expected_i) : timed_out)
                        tap_ok_reg <= 1'b0;
                    if (!timed_out) to_cnt_reg <= to_cnt_reg + 1'b1;
                end
                CAL_EVAL: begin
                    if (!reads_left) begin
                        pass_mask_reg[tap_reg] <= tap_ok_reg;
                        if (!last_tap) begin
                            tap_reg        <= tap_reg + 3'd1;
                            dqs_sel_reg    <= tap_reg + 3'd1;
                            rd_cnt_reg     <= '0;
                            settle_cnt_reg <= '0;
                            tap_ok_reg     <= 1'b1;
                        end
                    end
                end
                CAL_PICK: begin
                    done_reg    <= 1'b1;
                    fail_reg    <= !win_found;
                    dqs_sel_reg <= win_found ? win_tap : default_tap_lp;
                end
                default: ;
            endcase
        end
    end

    assign rd_req_o      = (state_reg == CAL_ISSUE);
    assign busy_o        = (state_reg != CAL_IDLE) && (state_reg != CAL_DONE);
    assign done_o        = done_reg;
    assign fail_o        = fail_reg;
    assign pass_mask_o   = pass_mask_reg;
    assign dqs_sel_cal_o = dqs_sel_reg;

endmodule

// File: tb/tb_bsg_dmc_dqs_gate_cal.sv
// Bench for the DQS gate calibrator: a behavioural controller/DRAM responder
// drives each sweep and a scoreboard predicts the pass mask and chosen tap.
module tb_bsg_dmc_dqs_gate_cal;

    localparam int DQ      = 8;
    localparam int BW      = 2 * DQ;
    localparam int R       = 4;
    localparam int SETTLE  = 8;
    localparam int TO      = 64;
    localparam int DEF_TAP = 6;

    logic          clk = 1'b0;
    logic          reset_i, start_i, rd_req_o, rd_ready_i, rddata_valid_i;
    logic          busy_o, done_o, fail_o;
    logic [BW-1:0] rddata_i, expected_i;
    logic [2:0]    dqs_sel_cal_o;
    logic [7:0]    pass_mask_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bsg_dmc_dqs_gate_cal #(
        .dq_data_width_p (DQ),
        .reads_per_tap_p (R),
        .settle_p        (SETTLE),
        .timeout_p       (TO),
        .default_tap_p   (DEF_TAP)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .rd_req_o       (rd_req_o),
        .rd_ready_i     (rd_ready_i),
        .rddata_valid_i (rddata_valid_i),
        .rddata_i       (rddata_i),
        .expected_i     (expected_i),
        .dqs_sel_cal_o  (dqs_sel_cal_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .fail_o         (fail_o),
        .pass_mask_o    (pass_mask_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference choice: search window lengths from widest down, starts from lowest up.
    function automatic void ref_pick(input logic [7:0] m, output logic f, output logic [2:0] t);
        logic [7:0] w;
        bit         hit;
        f   = 1'b1;
        t   = 3'(DEF_TAP);
        hit = 1'b0;
        for (int len = 8; len >= 1; len--) begin
            for (int s = 0; s + len <= 8; s++) begin
                w = 8'(((1 << len) - 1) << s);
                if (!hit && ((m & w) == w)) begin
                    hit = 1'b1;
                    f   = 1'b0;
                    t   = 3'(s + (len - 1) / 2);
                end
            end
        end
    endfunction

    task automatic check_reset_vals(input string name);
        check_eq({name, "/rst_rd_req"}, rd_req_o, 0);
        check_eq({name, "/rst_busy"}, busy_o, 0);
        check_eq({name, "/rst_done"}, done_o, 0);
        check_eq({name, "/rst_fail"}, fail_o, 0);
        check_eq({name, "/rst_mask"}, pass_mask_o, 0);
        check_eq({name, "/rst_dqs_sel"}, dqs_sel_cal_o, DEF_TAP);
    endtask

    // good: taps whose beats carry correct data; drop: taps whose reads never return.
    task automatic run_sweep(input string name, input logic [7:0] good, input logic [7:0] drop,
                             input bit late, input bit stall20, input bit rnd, input bit noise,
                             input int abort_tap, input bit start_mid);
        logic [7:0]    tap_bad, exp_mask;
        logic          exp_fail;
        logic [2:0]    exp_tap;
        logic [BW-1:0] beat;
        bit            send, aborted, fixed;
        int            cyc, accepts, phase, delay, stall_left, acc_cyc, tap0_cyc, late_at, tap;

        tap_bad    = '0;
        beat       = '0;
        send       = 1'b0;
        aborted    = 1'b0;
        fixed      = !rnd && !stall20 && (drop == 8'h00);
        cyc        = 0;
        accepts    = 0;
        phase      = 0;
        delay      = 0;
        acc_cyc    = 0;
        tap0_cyc   = 0;
        late_at    = -1;
        stall_left = rnd ? int'($urandom_range(0, 3)) : 0;
        expected_i = BW'($urandom);

        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        check_eq({name, "/busy_after_start"}, busy_o, 1);
        check_eq({name, "/done_cleared"}, done_o, 0);

        while (!aborted) begin
            @(negedge clk);
            cyc++;
            rd_ready_i     = 1'b0;
            rddata_valid_i = 1'b0;
            start_i        = 1'b0;
            if (done_o) break;
            if (cyc > 6000) begin
                check_eq({name, "/sweep_budget"}, 0, 1);
                break;
            end
            if (start_mid && cyc == 100) start_i = 1'b1;
            if (cyc == late_at) begin
                rddata_valid_i = 1'b1;
                rddata_i       = expected_i ^ BW'(1);
            end
            if (phase == 0) begin
                if (rd_req_o) begin
                    tap = accepts / R;
                    if (stall_left > 0) begin
                        stall_left--;
                        check_eq({name, "/stall_req_held"}, rd_req_o, 1);
                        check_eq({name, "/stall_tap_held"}, dqs_sel_cal_o, tap);
                    end else begin
                        rd_ready_i = 1'b1;
                        check_eq({name, "/tap_at_read"}, dqs_sel_cal_o, tap);
                        if (!rnd && (accepts % R) != 0)
                            check_eq({name, "/read_gap"}, cyc - acc_cyc, drop[tap] ? TO + 2 : 3);
                        if (fixed && (accepts % R) == 0 && accepts > 0)
                            check_eq({name, "/tap_period"}, cyc - tap0_cyc, SETTLE + R * 3);
                        if ((accepts % R) == 0) tap0_cyc = cyc;
                        acc_cyc = cyc;
                        send    = !drop[tap];
                        if (!good[tap] || (noise && $urandom_range(0, 15) == 0)) begin
                            beat         = expected_i ^ BW'($urandom_range(1, (1 << BW) - 1));
                            tap_bad[tap] = 1'b1;
                        end else begin
                            beat = expected_i;
                        end
                        if (drop[tap]) tap_bad[tap] = 1'b1;
                        if (drop[tap] && late && (accepts % R) == R - 1) late_at = cyc + TO + 5;
                        delay = rnd ? int'($urandom_range(1, 12)) : 1;
                        accepts++;
                        if (stall20 && accepts == 2 * R) stall_left = 20;
                        else stall_left = rnd ? int'($urandom_range(0, 3)) : 0;
                        phase = (abort_tap == tap) ? 2 : 1;
                    end
                end
            end else if (phase == 1) begin
                delay--;
                if (delay == 0) begin
                    if (send) begin
                        rddata_valid_i = 1'b1;
                        rddata_i       = beat;
                    end
                    phase = 0;
                end
            end else begin
                reset_i = 1'b1;
                @(negedge clk);
                reset_i = 1'b0;
                check_reset_vals({name, "/abort"});
                aborted = 1'b1;
            end
        end

        if (aborted) begin
            $display("sweep %s: reset during WAIT of tap %0d after %0d reads", name, abort_tap, accepts);
        end else begin
            exp_mask = ~tap_bad;
            ref_pick(exp_mask, exp_fail, exp_tap);
            check_eq({name, "/done"}, done_o, 1);
            check_eq({name, "/busy_end"}, busy_o, 0);
            check_eq({name, "/rd_req_end"}, rd_req_o, 0);
            check_eq({name, "/reads_issued"}, accepts, 8 * R);
            check_eq({name, "/pass_mask"}, pass_mask_o, exp_mask);
            check_eq({name, "/fail"}, fail_o, exp_fail);
            check_eq({name, "/dqs_sel"}, dqs_sel_cal_o, exp_tap);
            $display("sweep %s: mask=%b tap=%0d fail=%0d (model mask=%b tap=%0d fail=%0d)",
                     name, pass_mask_o, dqs_sel_cal_o, fail_o, exp_mask, exp_tap, exp_fail);
        end
    endtask

    initial begin
        reset_i        = 1'b1;
        start_i        = 1'b0;
        rd_ready_i     = 1'b0;
        rddata_valid_i = 1'b0;
        rddata_i       = '0;
        expected_i     = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("power_on");
        reset_i = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_busy", busy_o, 0);

        run_sweep("win_2_5",    8'b0011_1100, 8'h00, 0, 0, 0, 0, -1, 0);
        run_sweep("two_windows", 8'b0111_0011, 8'h00, 0, 0, 0, 0, -1, 0);
        run_sweep("equal_windows", 8'b0110_0110, 8'h00, 0, 0, 0, 0, -1, 0);
        run_sweep("all_fail",   8'b0000_0000, 8'h00, 0, 0, 0, 0, -1, 0);
        run_sweep("timeout_t3", 8'b1111_1111, 8'b0000_1000, 1, 0, 0, 0, -1, 0);
        run_sweep("ready_stall", 8'b0011_1100, 8'h00, 0, 1, 0, 0, -1, 0);
        run_sweep("rand_delay", 8'b0011_1100, 8'h00, 0, 0, 1, 0, -1, 0);
        run_sweep("abort_t4",   8'b1111_1111, 8'h00, 0, 0, 1, 0, 4, 0);
        run_sweep("after_abort", 8'b1111_1111, 8'h00, 0, 0, 1, 0, -1, 1);
        for (int i = 0; i < 4; i++)
            run_sweep($sformatf("random_%0d", i), 8'($urandom), 8'h00, 0, 0, 1, 1, -1, i[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
